// File: rtl/rast_pkg.sv
// Shared raster constants: 69-bit line word layout and screen limits.
// Used by the clipper, line setup and line generator.
package rast_pkg;

  localparam int WORD_W   = 69;
  localparam int X0_MSB   = 68;
  localparam int X0_LSB   = 59;
  localparam int Y0_MSB   = 58;
  localparam int Y0_LSB   = 49;
  localparam int X1_MSB   = 48;
  localparam int X1_LSB   = 39;
  localparam int Y1_MSB   = 38;
  localparam int Y1_LSB   = 29;
  localparam int DY_MSB   = 28;
  localparam int DY_LSB   = 18;
  localparam int DX_MSB   = 17;
  localparam int DX_LSB   = 7;
  localparam int COL_MSB  = 6;
  localparam int COL_LSB  = 4;
  localparam int VIS_BIT  = 3;
  localparam int RSV_MSB  = 2;
  localparam int RSV_LSB  = 1;
  localparam int PORN_BIT = 0;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic [10:0] dy;
    logic [10:0] dx;
    logic [2:0]  color;
    logic        line_vis;
    logic [1:0]  rsvd;
    logic        p_or_n;
  } raster_word_t;

  // Two's-complement magnitude of an 11-bit endpoint difference.
  function automatic logic [10:0] mag11(input logic [10:0] v);
    return v[10] ? (~v + 11'd1) : v;
  endfunction

endpackage

// File: rtl/line_setup_if.sv
// Clipper-to-setup and setup-to-line-generator signals of the line setup block.
// master drives lines and pops; slave is the line setup itself.
interface line_setup_if;
  import rast_pkg::*;

  logic              line_valid;
  logic              line_ready;
  logic [9:0]        x0;
  logic [9:0]        y0;
  logic [9:0]        x1;
  logic [9:0]        y1;
  logic [2:0]        color;
  logic              line_vis;
  logic              end_of_objects_in;
  logic              fifo_rd_en;
  logic [WORD_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              end_of_objects;

  modport master (
    output line_valid, x0, y0, x1, y1, color, line_vis, end_of_objects_in, fifo_rd_en,
    input  line_ready, fifo_data, fifo_empty, end_of_objects
  );

  modport slave (
    input  line_valid, x0, y0, x1, y1, color, line_vis, end_of_objects_in, fifo_rd_en,
    output line_ready, fifo_data, fifo_empty, end_of_objects
  );

endinterface

// File: rtl/line_fifo.sv
// First-word-fall-through FIFO; head shows combinationally, gated to 0 when empty.
// Pops on empty are ignored; writer must respect count (no internal full guard).
module line_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_rd;

  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      // Write and pop together leave count unchanged, including when full.
      if (wr_en && !do_rd)      count <= count + 1'b1;
      else if (!wr_en && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/line_setup.sv
// Line setup: S1 differences, S2 magnitudes/pack, then FWFT FIFO; accept-to-write latency 2.
// line_ready drops when FIFO words plus in-flight stages reach DEPTH; stages never stall.
module line_setup
  import rast_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  line_setup_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic              s1_v;
  logic [9:0]        s1_x0, s1_y0, s1_x1, s1_y1;
  logic [2:0]        s1_color;
  logic              s1_vis;
  logic [10:0]       s1_ex, s1_ey;
  logic              s2_v;
  raster_word_t      s2_word;
  raster_word_t      s2_next;
  logic [AW:0]       count;
  logic [AW+1:0]     inflight;
  logic              accept;
  logic              eoo_q;

  // Registered occupancy only, so a full pipeline can always land in the FIFO.
  assign inflight       = {1'b0, count} + (AW+2)'(s1_v) + (AW+2)'(s2_v);
  assign bus.line_ready = (inflight < (AW+2)'(DEPTH));
  assign accept         = bus.line_valid & bus.line_ready;

  always_comb begin
    s2_next          = '0;
    s2_next.x0       = s1_x0;
    s2_next.y0       = s1_y0;
    s2_next.x1       = s1_x1;
    s2_next.y1       = s1_y1;
    s2_next.dy       = mag11(s1_ey);
    s2_next.dx       = mag11(s1_ex);
    s2_next.color    = s1_color;
    s2_next.line_vis = s1_vis;
    s2_next.p_or_n   = (s1_ex[10] == s1_ey[10]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_x0    <= '0;
      s1_y0    <= '0;
      s1_x1    <= '0;
      s1_y1    <= '0;
      s1_color <= '0;
      s1_vis   <= 1'b0;
      s1_ex    <= '0;
      s1_ey    <= '0;
      s2_v     <= 1'b0;
      s2_word  <= '0;
      eoo_q    <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_x0    <= bus.x0;
        s1_y0    <= bus.y0;
        s1_x1    <= bus.x1;
        s1_y1    <= bus.y1;
        s1_color <= bus.color;
        s1_vis   <= bus.line_vis;
        s1_ex    <= {1'b0, bus.x1} - {1'b0, bus.x0};
        s1_ey    <= {1'b0, bus.y1} - {1'b0, bus.y0};
      end
      s2_v <= s1_v;
      if (s1_v) s2_word <= s2_next;
      // Held low while any line is entering or still inside S1/S2.
      eoo_q <= bus.end_of_objects_in & ~s1_v & ~s2_v & ~accept;
    end
  end

  assign bus.end_of_objects = eoo_q;

  line_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (s2_v),
    .din   (s2_word),
    .rd_en (bus.fifo_rd_en),
    .dout  (bus.fifo_data),
    .empty (bus.fifo_empty),
    .count (count)
  );

endmodule

// File: tb/tb_line_setup.sv
// Directed bench for line_setup: packing, backpressure, FWFT order, end-of-objects and reset.
module tb_line_setup;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  line_setup_if bus ();

  line_setup #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [68:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] mk(input int x0, input int y0, input int x1, input int y1,
                                     input int dy, input int dx, input int col, input int vis,
                                     input int porn);
    return {10'(x0), 10'(y0), 10'(x1), 10'(y1), 11'(dy), 11'(dx), 3'(col), 1'(vis), 2'b00, 1'(porn)};
  endfunction

  task automatic drive(input int x0, input int y0, input int x1, input int y1,
                       input int col, input int vis);
    bus.x0       = 10'(x0);
    bus.y0       = 10'(y0);
    bus.x1       = 10'(x1);
    bus.y1       = 10'(y1);
    bus.color    = 3'(col);
    bus.line_vis = 1'(vis);
  endtask

  // Series line n: (n,2n)->(n+7,2n+3), so dx=7, dy=3, same sign.
  task automatic drive_n(input int n);
    drive(n, 2*n, n+7, 2*n+3, n % 8, n % 2);
  endtask

  function automatic logic [68:0] word_n(input int n);
    return mk(n, 2*n, n+7, 2*n+3, 3, 7, n % 8, n % 2, 1);
  endfunction

  initial begin
    int n;
    int acc;
    int popped;
    int cyc;

    bus.line_valid        = 1'b0;
    bus.fifo_rd_en        = 1'b0;
    bus.end_of_objects_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset state
    #2;
    chk("rst_ready", 69'(bus.line_ready), 69'd1);
    chk("rst_empty", 69'(bus.fifo_empty), 69'd1);
    chk("rst_data",  bus.fifo_data, 69'd0);
    chk("rst_eoo",   69'(bus.end_of_objects), 69'd0);
    step();
    rst = 1'b0;
    step();

    // Basic line with 2-cycle latency
    drive(10, 20, 15, 23, 5, 1);
    bus.line_valid = 1'b1;
    step();
    bus.line_valid = 1'b0;
    step();
    chk("lat_empty_n1", 69'(bus.fifo_empty), 69'd1);
    step();
    chk("lat_empty_n2", 69'(bus.fifo_empty), 69'd0);
    chk("word_a", bus.fifo_data, mk(10, 20, 15, 23, 3, 5, 5, 1, 1));
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    chk("pop_a_empty", 69'(bus.fifo_empty), 69'd1);

    // Back-to-back: opposite signs (invisible), then both negative
    drive(100, 50, 40, 90, 2, 0);
    bus.line_valid = 1'b1;
    step();
    drive(639, 479, 0, 0, 7, 1);
    step();
    bus.line_valid = 1'b0;
    step();
    chk("word_b", bus.fifo_data, mk(100, 50, 40, 90, 40, 60, 2, 0, 0));
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    chk("word_c", bus.fifo_data, mk(639, 479, 0, 0, 479, 639, 7, 1, 1));
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    chk("pop_c_empty", 69'(bus.fifo_empty), 69'd1);

    // Fill with no pops: exactly DEPTH accepted
    n = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      drive_n(n);
      bus.line_valid = 1'b1;
      if (c == 7) chk("fill_ready_7", 69'(bus.line_ready), 69'd1);
      if (c == 8) chk("fill_ready_8", 69'(bus.line_ready), 69'd0);
      if (bus.line_ready) begin
        exp_q.push_back(word_n(n));
        n++;
        acc++;
      end
      step();
    end
    bus.line_valid = 1'b0;
    step();
    step();
    chk("fill_accepts", 69'(acc), 69'd8);
    chk("fill_ready_full", 69'(bus.line_ready), 69'd0);

    // Concurrent pop and offer: order over 20 popped words
    popped = 0;
    cyc = 0;
    while (popped < 20 && cyc < 200) begin
      drive_n(n);
      bus.line_valid = 1'b1;
      bus.fifo_rd_en = ~bus.fifo_empty;
      if (!bus.fifo_empty) begin
        chk("order_pop", bus.fifo_data, exp_q.pop_front());
        popped++;
      end
      if (bus.line_ready) begin
        exp_q.push_back(word_n(n));
        n++;
      end
      step();
      cyc++;
    end
    chk("order_popped", 69'(popped), 69'd20);
    bus.line_valid = 1'b0;
    bus.fifo_rd_en = 1'b0;
    step();
    step();
    cyc = 0;
    while (!bus.fifo_empty && cyc < 50) begin
      chk("drain_pop", bus.fifo_data, exp_q.pop_front());
      bus.fifo_rd_en = 1'b1;
      step();
      bus.fifo_rd_en = 1'b0;
      cyc++;
    end
    chk("drain_left", 69'(exp_q.size()), 69'd0);
    chk("drain_empty", 69'(bus.fifo_empty), 69'd1);

    // Pops while empty are ignored
    bus.fifo_rd_en = 1'b1;
    step();
    step();
    chk("epop_empty", 69'(bus.fifo_empty), 69'd1);
    chk("epop_data", bus.fifo_data, 69'd0);
    bus.fifo_rd_en = 1'b0;
    drive(300, 200, 310, 195, 3, 1);
    bus.line_valid = 1'b1;
    step();
    bus.line_valid = 1'b0;
    step();
    step();
    chk("epop_word", bus.fifo_data, mk(300, 200, 310, 195, 5, 10, 3, 1, 0));
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;
    chk("epop_after", 69'(bus.fifo_empty), 69'd1);

    // End-of-objects waits for the pipeline to drain
    drive(1, 1, 2, 2, 1, 1);
    bus.line_valid = 1'b1;
    step();
    bus.line_valid        = 1'b0;
    bus.end_of_objects_in = 1'b1;
    step();
    chk("eoo_s1", 69'(bus.end_of_objects), 69'd0);
    step();
    chk("eoo_s2", 69'(bus.end_of_objects), 69'd0);
    step();
    chk("eoo_rise", 69'(bus.end_of_objects), 69'd1);
    bus.end_of_objects_in = 1'b0;
    step();
    chk("eoo_fall", 69'(bus.end_of_objects), 69'd0);
    bus.fifo_rd_en = 1'b1;
    step();
    bus.fifo_rd_en = 1'b0;

    // Asynchronous reset with 3 words queued
    for (int i = 0; i < 3; i++) begin
      drive_n(40 + i);
      bus.line_valid = 1'b1;
      step();
    end
    bus.line_valid        = 1'b0;
    bus.end_of_objects_in = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_eoo", 69'(bus.end_of_objects), 69'd1);
    chk("pre_rst_head", bus.fifo_data, word_n(40));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 69'(bus.fifo_empty), 69'd1);
    chk("arst_eoo",   69'(bus.end_of_objects), 69'd0);
    chk("arst_data",  bus.fifo_data, 69'd0);
    chk("arst_ready", 69'(bus.line_ready), 69'd1);
    bus.end_of_objects_in = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_empty", 69'(bus.fifo_empty), 69'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
